seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. One shared
//   hex-to-segment decoder serves NUM_DIGITS digits, one digit at a time, with a guard interval

---
 rtl/seven_seg_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Display data is double-buffered and swapped only at frame boundaries.
module seven_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned GUARD_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned CntMax = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax);
   localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
   localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {StGuard, StShow} state_e;

   state_e                  state_q, state_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic                    frame_end;

   logic [4*NUM_DIGITS-1:0] disp_val_q, pend_val_q;
   logic [NUM_DIGITS-1:0]   disp_dp_q, pend_dp_q;
   logic                    pend_valid_q;
   logic                    commit;

   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_done_q;

   logic [3:0]              nib;
   logic                    dig_dp;
   logic                    blank;
   logic                    zero_run;

   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      case (h)
         4'h0: hex2seg = 7'h40;
         4'h1: hex2seg = 7'h79;
         4'h2: hex2seg = 7'h24;
         4'h3: hex2seg = 7'h30;
         4'h4: hex2seg = 7'h19;
         4'h5: hex2seg = 7'h12;
         4'h6: hex2seg = 7'h02;
         4'h7: hex2seg = 7'h78;
         4'h8: hex2seg = 7'h00;
         4'h9: hex2seg = 7'h10;
         4'hA: hex2seg = 7'h08;
         4'hB: hex2seg = 7'h03;
         4'hC: hex2seg = 7'h46;
         4'hD: hex2seg = 7'h21;
         4'hE: hex2seg = 7'h06;
         default: hex2seg = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StGuard;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q + CntW'(1);
      frame_end = 1'b0;
      if (!enable) begin
         state_d = StGuard;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StGuard: begin
               if (cnt_q == GuardLast) begin
                  state_d = StShow;
                  cnt_d   = '0;
               end
            end
            StShow: begin
               if (cnt_q == ShowLast) begin
                  state_d = StGuard;
                  cnt_d   = '0;
                  if (idx_q == IdxLast) begin
                     idx_d     = '0;
                     frame_end = 1'b1;
                  end else begin
                     idx_d = idx_q + IdxW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // While disabled there is no frame boundary to wait for, so pending data lands at once.
   assign commit = pend_valid_q && (frame_end || !enable);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         if (commit) begin
            disp_val_q <= pend_val_q;
            disp_dp_q  <= pend_dp_q;
         end
         if (load) begin
            pend_val_q <= value;
            pend_dp_q  <= dp_in;
         end
         if (load) pend_valid_q <= 1'b1;
         else if (commit) pend_valid_q <= 1'b0;
      end
   end

   // Select the current digit and detect whether it and all higher digits are zero.
   always_comb begin
      nib      = '0;
      dig_dp   = 1'b0;
      blank    = 1'b0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (disp_val_q[4*k +: 4] == 4'h0);
         if (idx_q == IdxW'(k)) begin
            nib    = disp_val_q[4*k +: 4];
            dig_dp = disp_dp_q[k];
            blank  = lz_en && (k != 0) && zero_run;
         end
      end
   end

   always_comb begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      an_d  = '1;
      if (enable && state_q == StShow) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_q);
         seg_d = blank ? 7'h7F : hex2seg(nib);
         dp_d  = ~dig_dp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_end;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a 4-digit, short-period configuration.
module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        lz_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4),
      .GUARD_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .load      (load),
      .value     (value),
      .dp_in     (dp_in),
      .lz_en     (lz_en),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // segs packed {dig3, dig2, dig1, dig0}; dpn is the expected active-low dp per digit
   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp_in;
      logic        lz;
      logic [27:0] segs;
      logic [3:0]  dpn;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Advance to the next falling edge and check that at most one anode is low.
   task automatic tick();
      @(negedge clk);
      chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic wait_frame_done();
      int n = 0;
      while (n < 60) begin
         tick();
         if (frame_done === 1'b1) break;
         n++;
      end
      chk("frame_done_timeout", 32'(n < 60), 32'd1);
   endtask

   // Called on the cycle frame_done is seen (or with the FSM in guard, counter 0, digit 0);
   // checks every cycle of the following frame.
   task automatic check_frame(input logic [27:0] segs, input logic [3:0] dpn, input string tag);
      logic [12:0] got, exp;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 6; c++) begin
            tick();
            load = 1'b0;
            got  = {an, seg, dp, frame_done};
            if (c < 2) exp = {4'hF, 7'h7F, 1'b1, 1'b0};
            else       exp = {~(4'b0001 << d), segs[d*7 +: 7], dpn[d], (d == 3 && c == 5)};
            chk($sformatf("%s dig%0d cyc%0d", tag, d, c), 32'(got), 32'(exp));
         end
      end
   endtask

   initial begin
      vecs[0] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
      vecs[1] = '{16'h0070, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111};
      vecs[2] = '{16'h0000, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
      vecs[3] = '{16'h3456, 4'b0001, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1110};
      vecs[4] = '{16'h7BE0, 4'b0000, 1'b1, {7'h78, 7'h03, 7'h06, 7'h40}, 4'b1111};
      vecs[5] = '{16'h89CD, 4'b1010, 1'b0, {7'h00, 7'h10, 7'h46, 7'h21}, 4'b0101};
      vecs[6] = '{16'h0100, 4'b0000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1111};

      rst_n  = 1'b0;
      enable = 1'b0;
      load   = 1'b0;
      value  = '0;
      dp_in  = '0;
      lz_en  = 1'b0;
      repeat (3) tick();
      chk("reset_state", 32'({an, seg, dp, frame_done}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
      rst_n = 1'b1;

      // Released but disabled: stays dark.
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("disabled_dark", 32'({an, seg, dp, frame_done}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
      end

      // Enable together with a load: first frame shows old (zero) data, then the new value.
      enable = 1'b1;
      value  = 16'h12AF;
      dp_in  = 4'b0100;
      load   = 1'b1;
      check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, "first_frame");
      check_frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011, "12AF");

      for (int i = 0; i < 7; i++) begin
         lz_en = vecs[i].lz;
         pulse_load(vecs[i].value, vecs[i].dp_in);
         wait_frame_done();
         check_frame(vecs[i].segs, vecs[i].dpn, $sformatf("vec%0d", i));
      end

      // Later load overwrites pending before the frame ends.
      lz_en = 1'b0;
      repeat (3) tick();
      pulse_load(16'h1111, 4'b0000);
      repeat (4) tick();
      pulse_load(16'h2222, 4'b0000);
      wait_frame_done();
      check_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111, "2222");

      // Load on the exact commit edge: old pending commits, new one waits a frame.
      pulse_load(16'h4444, 4'b0000);
      repeat (22) tick();
      pulse_load(16'h3333, 4'b0000);
      chk("commit_edge_frame_done", 32'(frame_done), 32'd1);
      check_frame({7'h19, 7'h19, 7'h19, 7'h19}, 4'b1111, "4444");
      check_frame({7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111, "3333");

      // Reset during digit 2 with data still pending.
      pulse_load(16'h9999, 4'b1111);
      repeat (15) tick();
      chk("pre_reset_dig2", 32'(an), 32'(4'b1011));
      #2 rst_n = 1'b0;
      #1 chk("async_reset_dark", 32'({an, seg, dp, frame_done}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
      repeat (2) tick();
      chk("reset_held_dark", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
      rst_n = 1'b1;
      check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, "post_reset0");
      check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, "post_reset1");

      // Disable: dark next cycle, load committed immediately, restart at digit 0 on enable.
      enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("disable_dark", 32'({an, seg, dp, frame_done}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
      end
      pulse_load(16'h5A5A, 4'b0000);
      tick();
      enable = 1'b1;
      check_frame({7'h12, 7'h08, 7'h12, 7'h08}, 4'b1111, "5A5A");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
